tlb_unit: RTL and testbench

TLB_UNIT -- requirements
Module: tlb_unit

---
 rtl/tlb_unit_pkg.sv | 53 +++++
 rtl/tlb_unit_match.sv | 45 ++++
 rtl/tlb_unit.sv | 132 +++++++++++++
 tb/tb_tlb_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_unit_pkg.sv
// Shared CPU definitions for the joint-pair TLB: entry/result layouts and the
// page-select/translate helper used by every lookup port.
package cpu_defs;

   localparam int TLB_ENTRIES_NUM = 16;

   typedef logic [$clog2(TLB_ENTRIES_NUM)-1:0] tlb_index_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef struct packed {
      logic        hit;
      logic        v;
      logic        d;
      logic [2:0]  c;
      logic [31:0] paddr;
   } tlb_result_t;

   // Picks the even/odd page by VA bit 12; a miss yields an all-zero result.
   function automatic tlb_result_t tlb_translate(input tlb_entry_t e, input logic hit,
                                                 input logic [12:0] va_lo);
      tlb_result_t res;
      res = '0;
      if (hit) begin
         res.hit = 1'b1;
         if (va_lo[12]) begin
            res.v     = e.v1;
            res.d     = e.d1;
            res.c     = e.c1;
            res.paddr = {e.pfn1, va_lo[11:0]};
         end else begin
            res.v     = e.v0;
            res.d     = e.d0;
            res.c     = e.c0;
            res.paddr = {e.pfn0, va_lo[11:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/tlb_unit_match.sv
// Associative match of a VPN2/ASID key against the whole entry array;
// reports a one-hot of the lowest matching entry, its index and a hit flag.
module tlb_match
   import cpu_defs::*;
#(
   parameter int TLB_ENTRIES = 16,
   parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
   input  tlb_entry_t [TLB_ENTRIES-1:0] i_entries,
   input  logic [18:0]                  i_vpn2,
   input  logic [7:0]                   i_asid,
   output logic [TLB_ENTRIES-1:0]       o_match,
   output logic [IDX_W-1:0]             o_index,
   output logic                         o_hit
);

   logic [TLB_ENTRIES-1:0] w_raw;
   logic                   w_unused_fields;

   assign w_unused_fields = ^i_entries;

   always_comb begin
      w_raw = '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         w_raw[i] = (i_entries[i].vpn2 == i_vpn2) &&
                    (i_entries[i].g || (i_entries[i].asid == i_asid));
      end
   end

   // Scan from the top so the lowest matching index is the last one kept.
   always_comb begin
      o_match = '0;
      o_index = '0;
      o_hit   = 1'b0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (w_raw[i]) begin
            o_match    = '0;
            o_match[i] = 1'b1;
            o_index    = IDX_W'(i);
            o_hit      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tlb_unit.sv
// Joint-pair TLB with two independent lookup ports, TLBWI write, TLBR read and
// TLBP probe. Define TLB_LOOKUP_PIPE_EN to register the lookup results.
module tlb_unit
   import cpu_defs::*;
#(
   parameter int TLB_ENTRIES = 16,
   parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       asid,
   input  logic             s0_req,
   input  logic [31:0]      s0_vaddr,
   input  logic             s0_stall,
   output logic             s0_valid,
   output logic             s0_hit,
   output logic             s0_v,
   output logic             s0_d,
   output logic [2:0]       s0_c,
   output logic [31:0]      s0_paddr,
   input  logic             s1_req,
   input  logic [31:0]      s1_vaddr,
   input  logic             s1_stall,
   output logic             s1_valid,
   output logic             s1_hit,
   output logic             s1_v,
   output logic             s1_d,
   output logic [2:0]       s1_c,
   output logic [31:0]      s1_paddr,
   input  logic             w_we,
   input  logic [IDX_W-1:0] w_index,
   input  tlb_entry_t       w_data,
   input  logic [IDX_W-1:0] r_index,
   output tlb_entry_t       r_data,
   input  logic [31:0]      p_entry_hi,
   output logic [31:0]      p_index
);

   tlb_entry_t [TLB_ENTRIES-1:0] r_tlb;

   logic                   w_s0_hit, w_s1_hit, w_p_hit;
   logic [IDX_W-1:0]       w_s0_idx, w_s1_idx, w_p_idx;
   logic [TLB_ENTRIES-1:0] w_unused_oh0, w_unused_oh1, w_unused_ohp;
   logic [4:0]             w_unused_phi;
   tlb_result_t            w_s0_res, w_s1_res, w_s0_out, w_s1_out;

   // Reset only invalidates; tags and PFNs keep whatever they held.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TLB_ENTRIES; i++) begin
            r_tlb[i].v0 <= 1'b0;
            r_tlb[i].v1 <= 1'b0;
            r_tlb[i].g  <= 1'b0;
         end
      end else if (w_we) begin
         r_tlb[w_index] <= w_data;
      end
   end

   tlb_match #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_match_s0 (
      .i_entries (r_tlb),
      .i_vpn2    (s0_vaddr[31:13]),
      .i_asid    (asid),
      .o_match   (w_unused_oh0),
      .o_index   (w_s0_idx),
      .o_hit     (w_s0_hit)
   );

   tlb_match #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_match_s1 (
      .i_entries (r_tlb),
      .i_vpn2    (s1_vaddr[31:13]),
      .i_asid    (asid),
      .o_match   (w_unused_oh1),
      .o_index   (w_s1_idx),
      .o_hit     (w_s1_hit)
   );

   tlb_match #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_match_p (
      .i_entries (r_tlb),
      .i_vpn2    (p_entry_hi[31:13]),
      .i_asid    (p_entry_hi[7:0]),
      .o_match   (w_unused_ohp),
      .o_index   (w_p_idx),
      .o_hit     (w_p_hit)
   );

   assign w_unused_phi = p_entry_hi[12:8];

   assign w_s0_res = tlb_translate(r_tlb[w_s0_idx], w_s0_hit, s0_vaddr[12:0]);
   assign w_s1_res = tlb_translate(r_tlb[w_s1_idx], w_s1_hit, s1_vaddr[12:0]);

   assign r_data  = r_tlb[r_index];
   assign p_index = w_p_hit ? 32'(w_p_idx) : 32'h8000_0000;

`ifdef TLB_LOOKUP_PIPE_EN
   logic        r_s0_valid, r_s1_valid;
   tlb_result_t r_s0_res, r_s1_res;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s0_valid <= 1'b0;
         r_s1_valid <= 1'b0;
      end else begin
         if (!s0_stall) r_s0_valid <= s0_req;
         if (!s1_stall) r_s1_valid <= s1_req;
      end
   end

   // Result data is not reset; valid qualifies it.
   always_ff @(posedge clk) begin
      if (!s0_stall) r_s0_res <= w_s0_res;
      if (!s1_stall) r_s1_res <= w_s1_res;
   end

   assign s0_valid = r_s0_valid;
   assign s1_valid = r_s1_valid;
   assign w_s0_out = r_s0_res;
   assign w_s1_out = r_s1_res;
`else
   logic w_unused_stall;

   assign w_unused_stall = s0_stall | s1_stall;
   assign s0_valid       = s0_req;
   assign s1_valid       = s1_req;
   assign w_s0_out       = w_s0_res;
   assign w_s1_out       = w_s1_res;
`endif

   assign {s0_hit, s0_v, s0_d, s0_c, s0_paddr} = w_s0_out;
   assign {s1_hit, s1_v, s1_d, s1_c, s1_paddr} = w_s1_out;

endmodule

// File: tb/tb_tlb_unit.sv
// Scoreboard bench for tlb_unit: directed scenarios plus random traffic against
// an entry-list reference model; works for both lookup builds.
module tb_tlb_unit;
   import cpu_defs::*;

   localparam int N  = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    asid = '0;
   logic          s0_req = 1'b0, s1_req = 1'b0, s0_stall = 1'b0, s1_stall = 1'b0;
   logic [31:0]   s0_vaddr = '0, s1_vaddr = '0;
   logic          s0_valid, s0_hit, s0_v, s0_d, s1_valid, s1_hit, s1_v, s1_d;
   logic [2:0]    s0_c, s1_c;
   logic [31:0]   s0_paddr, s1_paddr;
   logic          w_we = 1'b0;
   logic [IW-1:0] w_index = '0, r_index = '0;
   tlb_entry_t    w_data = '0, r_data;
   logic [31:0]   p_entry_hi = '0, p_index;

   tlb_unit #(.TLB_ENTRIES(N), .IDX_W(IW)) dut (
      .clk(clk), .reset(reset), .asid(asid),
      .s0_req(s0_req), .s0_vaddr(s0_vaddr), .s0_stall(s0_stall), .s0_valid(s0_valid),
      .s0_hit(s0_hit), .s0_v(s0_v), .s0_d(s0_d), .s0_c(s0_c), .s0_paddr(s0_paddr),
      .s1_req(s1_req), .s1_vaddr(s1_vaddr), .s1_stall(s1_stall), .s1_valid(s1_valid),
      .s1_hit(s1_hit), .s1_v(s1_v), .s1_d(s1_d), .s1_c(s1_c), .s1_paddr(s1_paddr),
      .w_we(w_we), .w_index(w_index), .w_data(w_data),
      .r_index(r_index), .r_data(r_data),
      .p_entry_hi(p_entry_hi), .p_index(p_index)
   );

   always #5 clk = ~clk;

   typedef struct { logic vonly; tlb_result_t r; } exp_t;
   typedef struct { logic [31:0] pidx; int rmode; tlb_entry_t rd; } pexp_t;

   exp_t       q0[$], q1[$];
   pexp_t      qp[$];
   tlb_entry_t m_tlb [N];
   int         n_vec = 0, n_err = 0;
   logic       p_chk = 1'b0, vonly = 1'b0;
   int         r_mode = 0;   // 0: probe only, 1: probe + full r_data, 2: r_data v0/v1/G only

   // Reference: first entry in index order whose tag matches, page by VA bit 12.
   function automatic tlb_result_t model_lookup(input logic [31:0] va, input logic [7:0] as);
      tlb_result_t r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (m_tlb[i].vpn2 == va[31:13] && (m_tlb[i].g || m_tlb[i].asid == as)) begin
            r.hit   = 1'b1;
            r.v     = va[12] ? m_tlb[i].v1 : m_tlb[i].v0;
            r.d     = va[12] ? m_tlb[i].d1 : m_tlb[i].d0;
            r.c     = va[12] ? m_tlb[i].c1 : m_tlb[i].c0;
            r.paddr = {(va[12] ? m_tlb[i].pfn1 : m_tlb[i].pfn0), va[11:0]};
            return r;
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] model_probe(input logic [31:0] hi);
      for (int i = 0; i < N; i++)
         if (m_tlb[i].vpn2 == hi[31:13] && (m_tlb[i].g || m_tlb[i].asid == hi[7:0]))
            return 32'(i);
      return 32'h8000_0000;
   endfunction

   function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] as, input logic g,
                                     input logic [19:0] pfn0, input logic [2:0] c0, input logic d0,
                                     input logic v0, input logic [19:0] pfn1, input logic [2:0] c1,
                                     input logic d1, input logic v1);
      tlb_entry_t e;
      e.vpn2 = vpn2; e.asid = as; e.g = g;
      e.pfn0 = pfn0; e.c0 = c0; e.d0 = d0; e.v0 = v0;
      e.pfn1 = pfn1; e.c1 = c1; e.d1 = d1; e.v1 = v1;
      return e;
   endfunction

   function automatic tlb_entry_t rand_entry();
      return mk(19'(32'h40 + $urandom_range(0, 3)), 8'(5 + $urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 20'($urandom), 3'($urandom), 1'($urandom),
                1'($urandom), 20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
   endfunction

   function automatic logic [31:0] rand_va();
      if ($urandom_range(0, 7) == 0) return $urandom;
      return {19'(32'h40 + $urandom_range(0, 3)), 13'($urandom)};
   endfunction

   task automatic push0(input tlb_result_t r, input logic vo);
      exp_t e;
      e.vonly = vo; e.r = r;
      q0.push_back(e);
   endtask

   task automatic push1(input tlb_result_t r, input logic vo);
      exp_t e;
      e.vonly = vo; e.r = r;
      q1.push_back(e);
   endtask

   task automatic pushp(input logic [31:0] pidx, input int rm, input tlb_entry_t rd);
      pexp_t p;
      p.pidx = pidx; p.rmode = rm; p.rd = rd;
      qp.push_back(p);
   endtask

   // Advance one cycle: mirror the edge into the model, then return inputs to idle.
   task automatic next();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_tlb[i].v0 = 1'b0; m_tlb[i].v1 = 1'b0; m_tlb[i].g = 1'b0;
         end
      end else if (w_we) begin
         m_tlb[w_index] = w_data;
      end
      #1;
      s0_req = 1'b0; s1_req = 1'b0; s0_stall = 1'b0; s1_stall = 1'b0;
      w_we = 1'b0; p_chk = 1'b0; vonly = 1'b0; r_mode = 0;
   endtask

   // Queue the model's answer for whatever is being driven this cycle.
   task automatic issue();
      logic g0, g1;
      g0 = s0_req;
      g1 = s1_req;
`ifdef TLB_LOOKUP_PIPE_EN
      g0 = g0 && !s0_stall;
      g1 = g1 && !s1_stall;
`endif
      if (g0) push0(model_lookup(s0_vaddr, asid), vonly);
      if (g1) push1(model_lookup(s1_vaddr, asid), vonly);
      if (p_chk) pushp(model_probe(p_entry_hi), r_mode, m_tlb[r_index]);
   endtask

   task automatic cmp_res(input string nm, input tlb_result_t a, input exp_t e);
      logic bad;
      n_vec++;
      bad = e.vonly ? (a.v !== e.r.v) : (a !== e.r);
      if (bad) begin
         n_err++;
         $display("FAIL %s actual hit=%0d v=%0d d=%0d c=%0d paddr=%h required hit=%0d v=%0d d=%0d c=%0d paddr=%h%s",
                  nm, a.hit, a.v, a.d, a.c, a.paddr, e.r.hit, e.r.v, e.r.d, e.r.c, e.r.paddr,
                  e.vonly ? " (v only)" : "");
      end
   endtask

   // Monitor: pops an expectation whenever a port presents a result.
   always @(negedge clk) begin
      exp_t  e;
      pexp_t p;
      if (s0_valid) begin
         if (q0.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL s0_valid actual=1 required=0");
         end else begin
            e = q0.pop_front();
            cmp_res("s0", {s0_hit, s0_v, s0_d, s0_c, s0_paddr}, e);
         end
      end
      if (s1_valid) begin
         if (q1.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL s1_valid actual=1 required=0");
         end else begin
            e = q1.pop_front();
            cmp_res("s1", {s1_hit, s1_v, s1_d, s1_c, s1_paddr}, e);
         end
      end
      if (p_chk && qp.size() != 0) begin
         p = qp.pop_front();
         if (p.rmode != 2) begin
            n_vec++;
            if (p_index !== p.pidx) begin
               n_err++;
               $display("FAIL probe actual=%h required=%h", p_index, p.pidx);
            end
         end
         if (p.rmode == 1) begin
            n_vec++;
            if (r_data !== p.rd) begin
               n_err++;
               $display("FAIL r_data actual=%h required=%h", r_data, p.rd);
            end
         end else if (p.rmode == 2) begin
            n_vec++;
            if ({r_data.v0, r_data.v1, r_data.g} !== {p.rd.v0, p.rd.v1, p.rd.g}) begin
               n_err++;
               $display("FAIL r_data_vg actual=%b required=%b",
                        {r_data.v0, r_data.v1, r_data.g}, {p.rd.v0, p.rd.v1, p.rd.g});
            end
         end
      end
   end

   initial begin
      tlb_result_t held;
      logic [31:0] va;

      reset = 1'b1;
      repeat (3) next();
      reset = 1'b0;

      // Known, non-matching contents everywhere.
      for (int i = 0; i < N; i++) begin
         next();
         w_we = 1'b1; w_index = IW'(i);
         w_data = mk(19'(32'h7FF00 + i), 8'h00, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
      end

      next();
      w_we = 1'b1; w_index = 4'd3;
      w_data = mk(19'h00040, 8'h05, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd2, 1'b0, 1'b0);
      next();
      asid = 8'h05;
      s0_req = 1'b1; s0_vaddr = 32'h0008_0ABC;
      push0({1'b1, 1'b1, 1'b1, 3'd3, 32'h1234_5ABC}, 1'b0);
      s1_req = 1'b1; s1_vaddr = 32'h0008_1ABC;
      push1({1'b1, 1'b0, 1'b0, 3'd2, 32'h5432_1ABC}, 1'b0);
      next();
      asid = 8'h06;
      s0_req = 1'b1; s0_vaddr = 32'h0008_0ABC;
      push0('0, 1'b0);
      w_we = 1'b1; w_index = 4'd3;
      w_data = mk(19'h00040, 8'h05, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd2, 1'b0, 1'b0);
      next();
      s0_req = 1'b1; s0_vaddr = 32'h0008_0ABC;
      push0({1'b1, 1'b1, 1'b1, 3'd3, 32'h1234_5ABC}, 1'b0);
      p_chk = 1'b1; p_entry_hi = 32'h0008_0005; r_index = 4'd3; r_mode = 1;
      pushp(32'd3, 1, m_tlb[3]);
      next();
      p_chk = 1'b1; p_entry_hi = 32'h7FFF_E005;
      pushp(32'h8000_0000, 0, m_tlb[0]);

      // Write and lookup of the same entry in one cycle sees the old contents.
      next();
      asid = 8'h05;
      w_we = 1'b1; w_index = 4'd5;
      w_data = mk(19'h00100, 8'h05, 1'b0, 20'hAAAAA, 3'd2, 1'b0, 1'b1, 20'hBBBBB, 3'd1, 1'b1, 1'b1);
      s1_req = 1'b1; s1_vaddr = 32'h0020_1345;
      push1('0, 1'b0);
      next();
      s1_req = 1'b1; s1_vaddr = 32'h0020_1345;
      push1({1'b1, 1'b1, 1'b1, 3'd1, 32'hBBBB_B345}, 1'b0);

`ifdef TLB_LOOKUP_PIPE_EN
      next();
      asid = 8'h05;
      s0_req = 1'b1; s0_vaddr = 32'h0008_0ABC;
      held = {1'b1, 1'b1, 1'b1, 3'd3, 32'h1234_5ABC};
      push0(held, 1'b0);
      for (int k = 0; k < 3; k++) begin
         next();
         s0_stall = 1'b1; s0_req = 1'b1; s0_vaddr = 32'h0020_1345;
         if (k == 0) begin
            w_we = 1'b1; w_index = 4'd3;
            w_data = mk(19'h00040, 8'h05, 1'b1, 20'h0F0F0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
         end
         push0(held, 1'b0);
      end
`else
      held = '0;
`endif

      for (int k = 0; k < 400; k++) begin
         next();
         asid = 8'(5 + $urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            w_we = 1'b1; w_index = IW'($urandom); w_data = rand_entry();
         end
         s0_req = 1'($urandom); s0_vaddr = rand_va();
         s1_req = 1'($urandom); s1_vaddr = rand_va();
         va = rand_va();
         p_chk = 1'b1; p_entry_hi = {va[31:13], 5'($urandom), 8'(5 + $urandom_range(0, 1))};
         r_index = IW'($urandom); r_mode = 1;
         issue();
      end

      // Reset after writes: every page must come back invalid.
      next();
      reset = 1'b1;
      next();
      next();
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         next();
         asid = 8'(5 + (k % 2));
         vonly = 1'b1;
         s0_req = 1'b1; s0_vaddr = {19'(32'h40 + (k / 2)), 1'b0, 12'h123};
         s1_req = 1'b1; s1_vaddr = {19'(32'h40 + (k / 2)), 1'b1, 12'h456};
         p_chk = 1'b1; r_index = 4'd3; r_mode = 2;
         issue();
      end

      next();
      for (int k = 0; k < 10 && (q0.size() + q1.size() + qp.size()) != 0; k++) next();
      if ((q0.size() + q1.size() + qp.size()) != 0) begin
         n_vec++; n_err++;
         $display("FAIL drain actual=%0d pending required=0", q0.size() + q1.size() + qp.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
